data_mem: RTL and testbench

- Shared data memory for the multicore NRISC datapath: one word array, Ncores=2 independent load/store ports.
- Each core gets its own address, write-data, read-data and load/write strobes.
- Writes are synchronous to clk.
- Reads are combinational, gated by the port's load strobe.
- The array is cleared by reset.

---
 rtl/data_mem_pkg.sv | 12 +
 rtl/data_mem_if.sv | 22 ++
 rtl/data_mem_wr_arb.sv | 18 +
 rtl/data_mem.sv | 38 +++
 tb/tb_data_mem.sv | 129 ++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared constants and types for the dual-port data memory.
//   NCORES - number of core ports (fixed at 2, ports are named per core)
//   LMEM   - decoded address bits, DEPTH = 2^LMEM words
//   TAM    - data/address word width
package data_mem_pkg;
   localparam int NCORES = 2;
   localparam int LMEM   = 8;
   localparam int TAM    = 16;
   localparam int DEPTH  = 1 << LMEM;
   typedef logic [TAM-1:0]  word_t;
   typedef logic [LMEM-1:0] addr_t;
endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: per-core load/store bus of the shared data memory.
//   dataIN0/1   write data           dataOUT0/1 read data
//   dataADDR0/1 word address         dataLoad   read strobes, bit i = core i
//   dataWrite   write strobes        dataErr    out-of-range flags (DATAMEM_RANGE_CHECK_EN only)
//   master = core side, slave = memory side.
interface data_mem_if;
   import data_mem_pkg::*;
   word_t dataIN0, dataIN1, dataOUT0, dataOUT1, dataADDR0, dataADDR1;
   logic [NCORES-1:0] dataLoad, dataWrite;
`ifdef DATAMEM_RANGE_CHECK_EN
   logic [NCORES-1:0] dataErr;
   modport master (output dataIN0, dataIN1, dataADDR0, dataADDR1, dataLoad, dataWrite,
                   input dataOUT0, dataOUT1, dataErr);
   modport slave  (input dataIN0, dataIN1, dataADDR0, dataADDR1, dataLoad, dataWrite,
                   output dataOUT0, dataOUT1, dataErr);
`else
   modport master (output dataIN0, dataIN1, dataADDR0, dataADDR1, dataLoad, dataWrite,
                   input dataOUT0, dataOUT1);
   modport slave  (input dataIN0, dataIN1, dataADDR0, dataADDR1, dataLoad, dataWrite,
                   output dataOUT0, dataOUT1);
`endif
endinterface

// File: rtl/data_mem_wr_arb.sv
// data_mem_wr_arb: turns raw write strobes into effective per-port write enables.
//   wr    raw write strobes        addr0/1 truncated word addresses
//   oor   out-of-range flags       we      effective write enables
// Core 0 wins a same-address collision; an out-of-range port never writes,
// so it cannot block the other port either.
module data_mem_wr_arb
   import data_mem_pkg::*;
(
   input  logic [NCORES-1:0] wr,
   input  addr_t             addr0,
   input  addr_t             addr1,
   input  logic [NCORES-1:0] oor,
   output logic [NCORES-1:0] we
);
   logic w0;
   assign w0 = wr[0] & ~oor[0];
   assign we = {wr[1] & ~oor[1] & ~(w0 & (addr0 == addr1)), w0};
endmodule

// File: rtl/data_mem.sv
// data_mem: 2-port shared data memory, synchronous writes, combinational gated reads.
//   clk  write clock             rst  async active-high reset, clears the array
//   bus  data_mem_if.slave       per-core address/data/strobes
// Optional macro DATAMEM_RANGE_CHECK_EN: addresses with upper bits set are
// rejected (no write, read 0) and flagged on bus.dataErr; otherwise they wrap.
module data_mem
   import data_mem_pkg::*;
(
   input logic       clk,
   input logic       rst,
   data_mem_if.slave bus
);
   word_t mem [DEPTH];
   addr_t a0, a1;
   logic [NCORES-1:0] hi, oor, we;
   assign a0 = bus.dataADDR0[LMEM-1:0];
   assign a1 = bus.dataADDR1[LMEM-1:0];
   assign hi = {|bus.dataADDR1[TAM-1:LMEM], |bus.dataADDR0[TAM-1:LMEM]};
`ifdef DATAMEM_RANGE_CHECK_EN
   assign oor = hi;
   assign bus.dataErr = (bus.dataLoad | bus.dataWrite) & oor;
`else
   logic unused;
   assign unused = ^hi;
   assign oor = '0;
`endif
   data_mem_wr_arb u_arb (.wr(bus.dataWrite), .addr0(a0), .addr1(a1), .oor(oor), .we(we));
   always_ff @(posedge clk or posedge rst)
      if (rst)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else begin
         if (we[0]) mem[a0] <= bus.dataIN0;
         if (we[1]) mem[a1] <= bus.dataIN1;
      end
   // the array is cleared asynchronously, so reads need no extra reset gating
   assign bus.dataOUT0 = (bus.dataLoad[0] && !oor[0]) ? mem[a0] : '0;
   assign bus.dataOUT1 = (bus.dataLoad[1] && !oor[1]) ? mem[a1] : '0;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: self-checking bench for data_mem (directed table, reset and random phases).
module tb_data_mem;
   import data_mem_pkg::*;
   logic clk = 0, rst = 1;
   data_mem_if bus ();
   data_mem dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
`ifdef DATAMEM_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
   localparam word_t X_CAFE = 16'h0000, X_1234 = 16'h0000, X_ABCD = 16'h0000;
`else
   localparam bit RC = 1'b0;
   localparam word_t X_CAFE = 16'hCAFE, X_1234 = 16'h1234, X_ABCD = 16'hABCD;
`endif
   typedef struct {
      logic [1:0] wr, ld;
      word_t      a0, d0, a1, d1, e0, e1;
   } vec_t;
   vec_t tbl[$];
   word_t ref_mem [DEPTH];
   int checks = 0, failures = 0;

   function automatic bit ok(word_t a);
      bit in_range = (a >> LMEM) == 0;
      return RC ? in_range : 1'b1;
   endfunction
   function automatic word_t rd(logic ld, word_t a);
      return (ld && ok(a)) ? ref_mem[a[LMEM-1:0]] : 16'h0000;
   endfunction
   task automatic check(input string nm, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask
   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask
   // one bus cycle: drive after the edge, check at negedge, commit the model at the edge
   task automatic step(input string nm, input logic [1:0] wr, input logic [1:0] ld,
                       input word_t a0, input word_t d0, input word_t a1, input word_t d1,
                       input word_t e0, input word_t e1);
      bus.dataWrite = wr; bus.dataLoad = ld;
      bus.dataADDR0 = a0; bus.dataIN0 = d0; bus.dataADDR1 = a1; bus.dataIN1 = d1;
      @(negedge clk);
      check({nm, "_out0"}, bus.dataOUT0, e0);
      check({nm, "_out1"}, bus.dataOUT1, e1);
`ifdef DATAMEM_RANGE_CHECK_EN
      check({nm, "_err"}, {14'd0, bus.dataErr},
            {14'd0, (ld[1] | wr[1]) & !ok(a1), (ld[0] | wr[0]) & !ok(a0)});
`endif
      @(posedge clk);
      // port 1 first so that port 0 overwrites it on a shared address
      if (wr[1] && ok(a1)) ref_mem[a1[LMEM-1:0]] = d1;
      if (wr[0] && ok(a0)) ref_mem[a0[LMEM-1:0]] = d0;
      #1;
   endtask

   initial begin
      word_t a0, a1, d0, d1;
      logic [1:0] wr, ld;
      clear_model();
      tbl.push_back('{2'b11, 2'b00, 16'h0012, 16'h1234, 16'h0034, 16'hABCD, 16'h0000, 16'h0000});
      tbl.push_back('{2'b00, 2'b11, 16'h0012, 16'h0000, 16'h0034, 16'h0000, 16'h1234, 16'hABCD});
      tbl.push_back('{2'b11, 2'b00, 16'h0040, 16'h1111, 16'h0040, 16'h2222, 16'h0000, 16'h0000});
      tbl.push_back('{2'b00, 2'b11, 16'h0040, 16'h0000, 16'h0040, 16'h0000, 16'h1111, 16'h1111});
      tbl.push_back('{2'b01, 2'b00, 16'h0055, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      tbl.push_back('{2'b01, 2'b10, 16'h0055, 16'h5A5A, 16'h0055, 16'h0000, 16'h0000, 16'h0A0A});
      tbl.push_back('{2'b00, 2'b10, 16'h0000, 16'h0000, 16'h0055, 16'h0000, 16'h0000, 16'h5A5A});
      tbl.push_back('{2'b01, 2'b00, 16'h01FF, 16'hCAFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      tbl.push_back('{2'b00, 2'b10, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, X_CAFE});
      tbl.push_back('{2'b00, 2'b00, 16'h0012, 16'h0000, 16'h0034, 16'h0000, 16'h0000, 16'h0000});
      tbl.push_back('{2'b00, 2'b11, 16'h0112, 16'h0000, 16'h0134, 16'h0000, X_1234, X_ABCD});
      tbl.push_back('{2'b01, 2'b00, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
      tbl.push_back('{2'b00, 2'b11, 16'h0010, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 16'hBEEF});

      bus.dataWrite = 2'b00; bus.dataLoad = 2'b11;
      bus.dataADDR0 = 16'h0010; bus.dataADDR1 = 16'h0020;
      bus.dataIN0 = '0; bus.dataIN1 = '0;
      repeat (2) @(negedge clk);
      check("init_out0", bus.dataOUT0, 16'h0000);
      check("init_out1", bus.dataOUT1, 16'h0000);
      @(posedge clk); #1 rst = 0;

      foreach (tbl[i])
         step($sformatf("vec%0d", i), tbl[i].wr, tbl[i].ld, tbl[i].a0, tbl[i].d0,
              tbl[i].a1, tbl[i].d1, tbl[i].e0, tbl[i].e1);

      // asynchronous reset mid-run while loading a written word
      bus.dataWrite = 2'b00; bus.dataLoad = 2'b11;
      bus.dataADDR0 = 16'h0010; bus.dataADDR1 = 16'h0010;
      #1 check("pre_rst_out0", bus.dataOUT0, 16'hBEEF);
      rst = 1;
      #1 check("rst_out0", bus.dataOUT0, 16'h0000);
      check("rst_out1", bus.dataOUT1, 16'h0000);
      bus.dataWrite = 2'b11; bus.dataIN0 = 16'hFFFF; bus.dataIN1 = 16'hFFFF;
      @(posedge clk); #1;
      check("rst_wr_out0", bus.dataOUT0, 16'h0000);
      bus.dataWrite = 2'b00;
      rst = 0;
      #1 check("post_rst_out0", bus.dataOUT0, 16'h0000);
      check("post_rst_out1", bus.dataOUT1, 16'h0000);
      clear_model();
      @(posedge clk); #1;

`ifdef DATAMEM_RANGE_CHECK_EN
      step("rc_seed", 2'b01, 2'b00, 16'h0000, 16'h7777, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      step("rc_wr", 2'b01, 2'b00, 16'h0100, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      step("rc_rd", 2'b00, 2'b11, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h7777, 16'h0000);
`endif

      for (int i = 0; i < 200; i++) begin
         wr = 2'($urandom_range(0, 3));
         ld = 2'($urandom_range(0, 3));
         a0 = 16'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a0[TAM-1:LMEM] = 8'($urandom);
         a1 = 16'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a1[TAM-1:LMEM] = 8'($urandom);
         if ($urandom_range(0, 7) == 0) a1 = a0;
         d0 = 16'($urandom);
         d1 = 16'($urandom);
         step($sformatf("rnd%0d", i), wr, ld, a0, d0, a1, d1, rd(ld[0], a0), rd(ld[1], a1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
